// File: rtl/wb_la_master.sv
// Single-outstanding Wishbone classic initiator: one command in, one byte-lane bus
// cycle with ack timeout, one response out. Timed-out transactions are counted.
module wb_la_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [7:0]  err_count,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; cmd_ready depends only on registered state, and rsp_valid, once raised,
  // holds with stable rsp_rdata/rsp_err until rsp_ready is seen.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       bus_ack;
  logic       bus_timeout;
  logic       unused_dat;

  assign cmd_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign dbg_state   = state;
  assign bus_ack     = (state == BUS) && wbm_ack_i;
  // Ack wins over timeout when both land in the same cycle.
  assign bus_timeout = (state == BUS) && !wbm_ack_i && (wait_cnt == LAST_WAIT);
  assign unused_dat  = &wbm_dat_i[31:8];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = BUS;
      BUS:     if (bus_ack || bus_timeout) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs double as the latched command; they hold after cyc/stb drop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'b0000;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
      wait_cnt  <= 8'h00;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      err_count <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= 4'b0001;
            wbm_adr_o <= cmd_addr;
            wbm_dat_o <= {24'h0, cmd_wdata};
            wait_cnt  <= 8'h00;
          end
        end
        BUS: begin
          if (bus_ack) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_rdata <= wbm_we_o ? 8'h00 : wbm_dat_i[7:0];
            rsp_err   <= 1'b0;
          end else if (bus_timeout) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_rdata <= 8'hFF;
            rsp_err   <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'h01;
          end else begin
            wait_cnt <= wait_cnt + 8'h01;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_la_master.sv
// Directed bench for wb_la_master: write, waited read, timeout, backpressure,
// ack-on-last-cycle, err_count saturation and reset in the middle of a bus cycle.
module tb_wb_la_master;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [8:0] exp_q[$];

  wb_la_master #(.TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one command; returns at the falling edge of the first BUS cycle.
  task automatic accept_cmd(input logic we, input logic [31:0] addr, input logic [7:0] wdata);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 8'h00;
  endtask

  // Slave model: acks on stb cycle waits+1 when do_ack; counts stb-high cycles.
  task automatic run_slave(input int waits, input logic [31:0] dat, input bit do_ack,
                           output int stb_cycles);
    stb_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (!wbm_stb_o) break;
      stb_cycles++;
      if (do_ack && stb_cycles == waits + 1) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = dat;
      end
      @(posedge clock);
      @(negedge clock);
      wbm_ack_i = 1'b0;
    end
    check("stb_dropped", wbm_stb_o, 0);
    check("cyc_dropped", wbm_cyc_o, 0);
  endtask

  // Called at the falling edge of a RESP cycle; scoreboards the response and drains it.
  task automatic finish_rsp();
    logic [8:0] e;
    check("rsp_valid_resp", rsp_valid, 1);
    if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("rsp_err_rdata", {23'h0, rsp_err, rsp_rdata}, {23'h0, e});
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    check("cmd_ready_after_rsp", cmd_ready, 1);
    check("rsp_valid_after_rsp", rsp_valid, 0);
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_we", wbm_we_o, 0);
    check("rst_sel", wbm_sel_o, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("cmd_ready_post_rst", cmd_ready, 1);

    // Stale ack in IDLE has no effect
    wbm_ack_i = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_ack_state", dbg_state, 0);
    check("idle_ack_rsp_valid", rsp_valid, 0);
    check("idle_ack_cyc", wbm_cyc_o, 0);
    wbm_ack_i = 1'b0;

    // Write, zero-wait ack: response two cycles after accept
    accept_cmd(1'b1, 32'h3000_0004, 8'hA5);
    check("wr_cyc", wbm_cyc_o, 1);
    check("wr_stb", wbm_stb_o, 1);
    check("wr_we", wbm_we_o, 1);
    check("wr_adr", wbm_adr_o, 32'h3000_0004);
    check("wr_dat", wbm_dat_o, 32'h0000_00A5);
    check("wr_sel", wbm_sel_o, 4'b0001);
    check("wr_cmd_ready_busy", cmd_ready, 0);
    check("wr_rsp_valid_early", rsp_valid, 0);
    exp_q.push_back({1'b0, 8'h00});
    run_slave(0, 32'hFFFF_FFFF, 1'b1, n);
    check("wr_stb_cycles", n, 1);
    finish_rsp();

    // Read with three wait states
    accept_cmd(1'b0, 32'h0000_0100, 8'h77);
    check("rd_we", wbm_we_o, 0);
    check("rd_adr", wbm_adr_o, 32'h0000_0100);
    check("rd_dat", wbm_dat_o, 32'h0000_0077);
    exp_q.push_back({1'b0, 8'h5C});
    run_slave(3, 32'hDEAD_BE5C, 1'b1, n);
    check("rd_stb_cycles", n, 4);
    finish_rsp();

    // Timeout, then a late ack in RESP
    accept_cmd(1'b0, 32'h4000_0000, 8'h00);
    exp_q.push_back({1'b1, 8'hFF});
    run_slave(0, 32'h0, 1'b0, n);
    check("to_stb_cycles", n, 16);
    check("to_err_count", err_count, 1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0000_0011;
    @(posedge clock);
    @(negedge clock);
    wbm_ack_i = 1'b0;
    check("late_ack_state", dbg_state, 2);
    check("late_ack_rdata", rsp_rdata, 8'hFF);
    check("late_ack_err", rsp_err, 1);
    check("late_ack_err_count", err_count, 1);
    finish_rsp();

    // Backpressure: rsp_ready low for 10 cycles
    accept_cmd(1'b0, 32'h0000_0200, 8'h00);
    exp_q.push_back({1'b0, 8'h78});
    run_slave(0, 32'h1234_5678, 1'b1, n);
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, 8'h78);
      check("bp_err", rsp_err, 0);
      check("bp_cmd_ready", cmd_ready, 0);
      @(posedge clock);
      @(negedge clock);
    end
    finish_rsp();

    // Ack on the final timeout cycle wins
    accept_cmd(1'b0, 32'h0000_0300, 8'h00);
    exp_q.push_back({1'b0, 8'h3C});
    run_slave(15, 32'h0000_003C, 1'b1, n);
    check("edge_stb_cycles", n, 16);
    check("edge_err_count", err_count, 1);
    finish_rsp();

    // Saturation: 300 more timeouts
    for (int t = 0; t < 300; t++) begin
      accept_cmd(1'b0, 32'h5000_0000, 8'h00);
      exp_q.push_back({1'b1, 8'hFF});
      run_slave(0, 32'h0, 1'b0, n);
      finish_rsp();
    end
    check("sat_err_count", err_count, 8'hFF);

    // Reset during cycle 2 of a read
    accept_cmd(1'b0, 32'h0000_0400, 8'h00);
    check("mid_stb_c1", wbm_stb_o, 1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_cyc", wbm_cyc_o, 0);
    check("mid_rst_stb", wbm_stb_o, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_err_count", err_count, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_state", dbg_state, 0);
      @(negedge clock);
    end

    // Normal operation resumes after reset
    accept_cmd(1'b0, 32'h0000_0500, 8'h00);
    exp_q.push_back({1'b0, 8'hC3});
    run_slave(1, 32'h0000_00C3, 1'b1, n);
    check("resume_stb_cycles", n, 2);
    finish_rsp();
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
